// File: rtl/mem_resp_pkg.sv
// Shared types and sizing helpers for the processing-block main-memory responder.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam int DEFAULT_LATENCY = 2;
    localparam int LAT_CNT_W       = $clog2(DEFAULT_LATENCY + 1);

    function automatic int calc_ww(input int cores, input int bits);
        return cores * bits;
    endfunction

    // Counter must hold LATENCY-1; keep at least one bit for LATENCY=1 builds.
    function automatic int lat_cnt_width(input int latency);
        return (latency < 1) ? 1 : $clog2(latency + 1);
    endfunction

endpackage

// File: rtl/main_memory_responder_rr_arbiter.sv
// Combinational rotating-priority arbiter; the pointer register lives in the parent.
module rr_arbiter #(
    parameter int  N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] winner
);

    logic found_s;
    logic hit_s;
    int   idx_s;

    // Search upward from ptr with wrap; the first requester found wins.
    always_comb begin
        gnt     = '0;
        winner  = '0;
        found_s = 1'b0;
        hit_s   = 1'b0;
        idx_s   = 0;
        for (int k = 0; k < N; k++) begin
            idx_s      = (int'(ptr) + k) % N;
            hit_s      = req[idx_s] & ~found_s;
            gnt[idx_s] = hit_s;
            winner     = hit_s ? IW'(idx_s) : winner;
            found_s    = found_s | hit_s;
        end
    end

endmodule

// File: rtl/main_memory_responder.sv
// Main-memory responder: round-robin arbitration of block load/write requests over
// a single-port word array, with fixed-latency one-hot load responses.
module main_memory_responder
    import mem_resp_pkg::*;
#(
    parameter int  NUM_BLOCKS = 4,
    parameter int  CORES      = 32,
    parameter int  BITS       = 16,
    parameter int  ADDR_BITS  = 10,
    parameter int  LATENCY    = DEFAULT_LATENCY,
    localparam int WW         = calc_ww(CORES, BITS)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_BLOCKS-1:0]   req_load,
    input  logic [NUM_BLOCKS-1:0]   req_write,
    input  logic [NUM_BLOCKS*16-1:0] req_load_addr,
    input  logic [NUM_BLOCKS*16-1:0] req_write_addr,
    input  logic [NUM_BLOCKS*WW-1:0] req_write_data,
    output logic [NUM_BLOCKS-1:0]   grant,
    output logic [NUM_BLOCKS-1:0]   resp_valid,
    output logic [WW-1:0]           resp_data,
    output logic                    busy,
    output logic                    err_conflict
);

    localparam int IW    = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int CW    = lat_cnt_width(LATENCY);
    localparam int DEPTH = 2 ** ADDR_BITS;

    state_t                state_r;
    logic [IW-1:0]         ptr_r;
    logic [CW-1:0]         cnt_r;
    logic [NUM_BLOCKS-1:0] grant_r;
    logic [NUM_BLOCKS-1:0] resp_valid_r;
    logic [NUM_BLOCKS-1:0] owner_r;
    logic [WW-1:0]         resp_data_r;
    logic [WW-1:0]         rd_r;
    logic                  busy_r;
    logic                  err_r;
    logic [WW-1:0]         mem_r [DEPTH];

    logic [NUM_BLOCKS-1:0] req_any_s;
    logic [NUM_BLOCKS-1:0] gnt_s;
    logic [IW-1:0]         winner_s;
    logic [IW-1:0]         ptr_nx_s;
    logic                  arb_s;
    logic                  win_load_s;
    logic                  win_write_s;
    logic                  mem_we_s;
    logic                  mem_re_s;
    logic [ADDR_BITS-1:0]  raddr_s;
    logic [ADDR_BITS-1:0]  waddr_s;
    logic [WW-1:0]         wdata_s;
    logic                  unused_addr_s;

    rr_arbiter #(.N(NUM_BLOCKS)) u_arb (
        .req    (req_any_s),
        .ptr    (ptr_r),
        .gnt    (gnt_s),
        .winner (winner_s)
    );

    // Decode the winner's request kind and its address/data slices.
    always_comb begin
        req_any_s   = req_load | req_write;
        arb_s       = (state_r == IDLE) && (|req_any_s);
        win_load_s  = req_load[winner_s];
        win_write_s = req_write[winner_s];
        raddr_s     = req_load_addr[int'(winner_s) * 16 +: ADDR_BITS];
        waddr_s     = req_write_addr[int'(winner_s) * 16 +: ADDR_BITS];
        wdata_s     = req_write_data[int'(winner_s) * WW +: WW];
        mem_we_s    = arb_s && win_write_s && !reset;
        mem_re_s    = arb_s && !win_write_s && win_load_s && !reset;
        ptr_nx_s    = (winner_s == IW'(NUM_BLOCKS - 1)) ? '0 : winner_s + IW'(1);
    end

    // Upper address bits are ignored so addresses wrap modulo the depth.
    always_comb begin
        unused_addr_s = 1'b0;
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            unused_addr_s = unused_addr_s
                          ^ (^req_load_addr[i*16+ADDR_BITS +: 16-ADDR_BITS])
                          ^ (^req_write_addr[i*16+ADDR_BITS +: 16-ADDR_BITS]);
        end
    end

    // Memory array write port; contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            mem_r[waddr_s] <= wdata_s;
        end
    end

    // Read register; doubles as the response bus when LATENCY is 1.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_r <= '0;
        end else if (mem_re_s) begin
            rd_r <= mem_r[raddr_s];
        end else if (state_r == RESP) begin
            rd_r <= '0;
        end else begin
            rd_r <= rd_r;
        end
    end

    // Arbitration, latency sequencing and the registered handshake outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= IDLE;
            ptr_r        <= '0;
            cnt_r        <= '0;
            grant_r      <= '0;
            resp_valid_r <= '0;
            owner_r      <= '0;
            resp_data_r  <= '0;
            busy_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            grant_r      <= '0;
            resp_valid_r <= '0;
            resp_data_r  <= '0;
            case (state_r)
                IDLE: begin
                    if (arb_s) begin
                        grant_r <= gnt_s;
                        owner_r <= gnt_s;
                        ptr_r   <= ptr_nx_s;
                        busy_r  <= 1'b1;
                        // Write wins a load/write conflict; the load is dropped.
                        if (win_write_s) begin
                            state_r <= HOLD;
                            err_r   <= err_r | win_load_s;
                        end else if (LATENCY == 1) begin
                            state_r      <= RESP;
                            resp_valid_r <= gnt_s;
                        end else begin
                            state_r <= WAIT;
                            cnt_r   <= CW'(1);
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                HOLD: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                WAIT: begin
                    if (cnt_r == CW'(LATENCY - 1)) begin
                        state_r      <= RESP;
                        resp_valid_r <= owner_r;
                        resp_data_r  <= rd_r;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign grant        = grant_r;
    assign resp_valid   = resp_valid_r;
    assign resp_data    = (LATENCY == 1) ? rd_r : resp_data_r;
    assign busy         = busy_r;
    assign err_conflict = err_r;

endmodule

// File: tb/tb_main_memory_responder.sv
// Scoreboard bench for main_memory_responder: LATENCY=2 default build plus a LATENCY=1 build.
module tb_main_memory_responder;

    localparam int NB = 4;
    localparam int WW = 512;

    logic clock = 1'b0;
    logic reset;
    logic [NB-1:0]    req_load, req_write, grant, resp_valid;
    logic [NB*16-1:0] req_load_addr, req_write_addr;
    logic [NB*WW-1:0] req_write_data;
    logic [WW-1:0]    resp_data;
    logic             busy, err_conflict;

    logic [NB-1:0]    l1_req_load, l1_req_write, l1_grant, l1_resp_valid;
    logic [NB*16-1:0] l1_req_load_addr, l1_req_write_addr;
    logic [NB*WW-1:0] l1_req_write_data;
    logic [WW-1:0]    l1_resp_data;
    logic             l1_busy, l1_err_conflict;

    typedef struct {
        int            cyc;
        logic [NB-1:0] v;
        logic [WW-1:0] d;
    } ev_t;

    ev_t gq[$], rq[$], g1q[$], r1q[$], exp_q[$];
    int  cyc    = 0;
    int  total  = 0;
    int  passed = 0;

    main_memory_responder dut (
        .clock(clock), .reset(reset),
        .req_load(req_load), .req_write(req_write),
        .req_load_addr(req_load_addr), .req_write_addr(req_write_addr),
        .req_write_data(req_write_data),
        .grant(grant), .resp_valid(resp_valid), .resp_data(resp_data),
        .busy(busy), .err_conflict(err_conflict)
    );

    main_memory_responder #(.LATENCY(1)) dut1 (
        .clock(clock), .reset(reset),
        .req_load(l1_req_load), .req_write(l1_req_write),
        .req_load_addr(l1_req_load_addr), .req_write_addr(l1_req_write_addr),
        .req_write_data(l1_req_write_data),
        .grant(l1_grant), .resp_valid(l1_resp_valid), .resp_data(l1_resp_data),
        .busy(l1_busy), .err_conflict(l1_err_conflict)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Record grants and responses mid-cycle, away from the active edge.
    always @(negedge clock) begin
        if (grant != '0)         gq.push_back('{cyc, grant, {WW{1'b0}}});
        if (resp_valid != '0)    rq.push_back('{cyc, resp_valid, resp_data});
        if (l1_grant != '0)      g1q.push_back('{cyc, l1_grant, {WW{1'b0}}});
        if (l1_resp_valid != '0) r1q.push_back('{cyc, l1_resp_valid, l1_resp_data});
    end

    function automatic logic [WW-1:0] lanes(input logic [15:0] v);
        return {32{v}};
    endfunction

    task automatic drive(input int b, input bit ld, input bit wr, input logic [15:0] a, input logic [15:0] v);
        req_load[b] = ld;
        req_write[b] = wr;
        req_load_addr[b*16 +: 16] = a;
        req_write_addr[b*16 +: 16] = a;
        req_write_data[b*WW +: WW] = lanes(v);
    endtask

    task automatic drive1(input int b, input bit ld, input bit wr, input logic [15:0] a, input logic [15:0] v);
        l1_req_load[b] = ld;
        l1_req_write[b] = wr;
        l1_req_load_addr[b*16 +: 16] = a;
        l1_req_write_addr[b*16 +: 16] = a;
        l1_req_write_data[b*WW +: WW] = lanes(v);
    endtask

    // Advance n cycles; each requester drops its request once it sees its grant.
    task automatic run(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            for (int b = 0; b < NB; b++) begin
                if (grant[b]) begin req_load[b] = 1'b0; req_write[b] = 1'b0; end
                if (l1_grant[b]) begin l1_req_load[b] = 1'b0; l1_req_write[b] = 1'b0; end
            end
        end
    endtask

    task automatic clear_q();
        gq.delete(); rq.delete(); g1q.delete(); r1q.delete(); exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        run(3);
        total++; if (grant !== 4'b0000) $display("FAIL reset_grant got=%b exp=0000", grant); else passed++;
        total++; if (resp_valid !== 4'b0000) $display("FAIL reset_resp_valid got=%b exp=0000", resp_valid); else passed++;
        total++; if (resp_data !== {WW{1'b0}}) $display("FAIL reset_resp_data got=%h exp=0", resp_data); else passed++;
        total++; if ({busy, err_conflict} !== 2'b00) $display("FAIL reset_busy_err got=%b exp=00", {busy, err_conflict}); else passed++;
        reset = 1'b0;
        run(1);
    endtask

    task automatic test_write_load();
        int rc;
        ev_t o, e;
        clear_q();
        drive(0, 1'b0, 1'b1, 16'd5, 16'h3F80);
        rc = cyc;
        run(4);
        total++; if (gq.size() != 1) $display("FAIL wl_write_grant_count got=%0d exp=1", gq.size()); else passed++;
        if (gq.size() >= 1) begin
            total++;
            if (gq[0].v !== 4'b0001 || gq[0].cyc != rc + 1)
                $display("FAIL wl_write_grant got=%b@%0d exp=0001@%0d", gq[0].v, gq[0].cyc, rc + 1);
            else passed++;
        end
        total++; if (rq.size() != 0) $display("FAIL wl_write_no_resp got=%0d exp=0", rq.size()); else passed++;
        clear_q();
        exp_q.push_back('{0, 4'b0001, lanes(16'h3F80)});
        drive(0, 1'b1, 1'b0, 16'd5, 16'h0000);
        rc = cyc;
        run(6);
        total++; if (rq.size() != exp_q.size()) $display("FAIL wl_resp_count got=%0d exp=%0d", rq.size(), exp_q.size()); else passed++;
        if (rq.size() >= 1) begin
            total++; if (rq[0].cyc != rc + 2) $display("FAIL wl_resp_time got=%0d exp=%0d", rq[0].cyc, rc + 2); else passed++;
        end
        while (rq.size() > 0 && exp_q.size() > 0) begin
            o = rq.pop_front(); e = exp_q.pop_front();
            total++;
            if (o.v !== e.v || o.d !== e.d) $display("FAIL wl_resp got v=%b d=%h exp v=%b d=%h", o.v, o.d, e.v, e.d);
            else passed++;
        end
        total++; if (resp_data !== {WW{1'b0}}) $display("FAIL wl_resp_data_idle got=%h exp=0", resp_data); else passed++;
    endtask

    task automatic test_round_robin(input int first, input logic [15:0] base);
        int rc, w;
        ev_t o, e;
        w = (first + NB - 1) % NB;
        for (int i = 0; i < NB; i++) begin
            drive(w, 1'b0, 1'b1, 16'(i + 1), base + 16'(i));
            run(3);
        end
        clear_q();
        for (int b = 0; b < NB; b++) drive(b, 1'b1, 1'b0, 16'(b + 1), 16'h0000);
        for (int k = 0; k < NB; k++) exp_q.push_back('{0, 4'b0001 << ((first + k) % NB), lanes(base + 16'((first + k) % NB))});
        rc = cyc;
        run(16);
        total++; if (gq.size() != NB) $display("FAIL rr%0d_grant_count got=%0d exp=%0d", first, gq.size(), NB); else passed++;
        for (int k = 0; k < NB && k < gq.size(); k++) begin
            total++;
            if (gq[k].v !== (4'b0001 << ((first + k) % NB)) || gq[k].cyc != rc + 1 + 3 * k)
                $display("FAIL rr%0d_grant%0d got=%b@%0d exp=%b@%0d", first, k, gq[k].v, gq[k].cyc,
                         4'b0001 << ((first + k) % NB), rc + 1 + 3 * k);
            else passed++;
        end
        total++; if (rq.size() != exp_q.size()) $display("FAIL rr%0d_resp_count got=%0d exp=%0d", first, rq.size(), exp_q.size()); else passed++;
        while (rq.size() > 0 && exp_q.size() > 0) begin
            o = rq.pop_front(); e = exp_q.pop_front();
            total++;
            if (o.v !== e.v || o.d !== e.d) $display("FAIL rr%0d_resp got v=%b d=%h exp v=%b d=%h", first, o.v, o.d, e.v, e.d);
            else passed++;
        end
    endtask

    task automatic test_wrap();
        ev_t o, e;
        drive(2, 1'b0, 1'b1, 16'h0405, 16'h5A5A);
        run(3);
        clear_q();
        exp_q.push_back('{0, 4'b0100, lanes(16'h5A5A)});
        drive(2, 1'b1, 1'b0, 16'h0005, 16'h0000);
        run(5);
        total++; if (rq.size() != exp_q.size()) $display("FAIL wrap_resp_count got=%0d exp=%0d", rq.size(), exp_q.size()); else passed++;
        while (rq.size() > 0 && exp_q.size() > 0) begin
            o = rq.pop_front(); e = exp_q.pop_front();
            total++;
            if (o.v !== e.v || o.d !== e.d) $display("FAIL wrap_resp got v=%b d=%h exp v=%b d=%h", o.v, o.d, e.v, e.d);
            else passed++;
        end
    endtask

    task automatic test_conflict();
        ev_t o, e;
        clear_q();
        total++; if (err_conflict !== 1'b0) $display("FAIL conf_err_before got=%b exp=0", err_conflict); else passed++;
        drive(1, 1'b1, 1'b1, 16'd7, 16'hAAAA);
        run(6);
        total++; if (gq.size() != 1 || (gq.size() == 1 && gq[0].v !== 4'b0010)) $display("FAIL conf_grant count=%0d exp one grant 0010", gq.size()); else passed++;
        total++; if (rq.size() != 0) $display("FAIL conf_no_resp got=%0d exp=0", rq.size()); else passed++;
        total++; if (err_conflict !== 1'b1) $display("FAIL conf_err got=%b exp=1", err_conflict); else passed++;
        clear_q();
        exp_q.push_back('{0, 4'b0010, lanes(16'hAAAA)});
        drive(1, 1'b1, 1'b0, 16'd7, 16'h0000);
        run(5);
        total++; if (rq.size() != exp_q.size()) $display("FAIL conf_resp_count got=%0d exp=%0d", rq.size(), exp_q.size()); else passed++;
        while (rq.size() > 0 && exp_q.size() > 0) begin
            o = rq.pop_front(); e = exp_q.pop_front();
            total++;
            if (o.v !== e.v || o.d !== e.d) $display("FAIL conf_readback got v=%b d=%h exp v=%b d=%h", o.v, o.d, e.v, e.d);
            else passed++;
        end
        total++; if (err_conflict !== 1'b1) $display("FAIL conf_err_sticky got=%b exp=1", err_conflict); else passed++;
    endtask

    task automatic test_reset_mid();
        ev_t o, e;
        drive(3, 1'b0, 1'b1, 16'd9, 16'hC0DE);
        run(3);
        clear_q();
        drive(0, 1'b1, 1'b0, 16'd9, 16'h0000);
        run(1);
        total++; if ({grant, busy} !== 5'b00011) $display("FAIL rst_mid_pre got=%b exp=00011", {grant, busy}); else passed++;
        reset = 1'b1;
        run(1);
        total++;
        if ({grant, resp_valid, busy, err_conflict} !== 10'b0 || resp_data !== {WW{1'b0}})
            $display("FAIL rst_mid_outputs got=%b data=%h exp all zero", {grant, resp_valid, busy, err_conflict}, resp_data);
        else passed++;
        reset = 1'b0;
        run(6);
        total++; if (rq.size() != 0) $display("FAIL rst_mid_no_resp got=%0d exp=0", rq.size()); else passed++;
        clear_q();
        exp_q.push_back('{0, 4'b0001, lanes(16'hC0DE)});
        drive(0, 1'b1, 1'b0, 16'd9, 16'h0000);
        run(5);
        total++; if (rq.size() != exp_q.size()) $display("FAIL rst_mid_resp_count got=%0d exp=%0d", rq.size(), exp_q.size()); else passed++;
        while (rq.size() > 0 && exp_q.size() > 0) begin
            o = rq.pop_front(); e = exp_q.pop_front();
            total++;
            if (o.v !== e.v || o.d !== e.d) $display("FAIL rst_mid_readback got v=%b d=%h exp v=%b d=%h", o.v, o.d, e.v, e.d);
            else passed++;
        end
    endtask

    task automatic test_latency1();
        int rc;
        drive1(3, 1'b0, 1'b1, 16'd3, 16'h7777);
        run(3);
        drive1(3, 1'b0, 1'b1, 16'd4, 16'h8888);
        run(3);
        clear_q();
        drive1(0, 1'b1, 1'b0, 16'd3, 16'h0000);
        drive1(1, 1'b1, 1'b0, 16'd4, 16'h0000);
        exp_q.push_back('{0, 4'b0001, lanes(16'h7777)});
        exp_q.push_back('{0, 4'b0010, lanes(16'h8888)});
        rc = cyc;
        run(8);
        total++; if (g1q.size() != 2 || r1q.size() != 2) $display("FAIL l1_counts got grants=%0d resps=%0d exp 2/2", g1q.size(), r1q.size()); else passed++;
        if (g1q.size() == 2 && r1q.size() == 2) begin
            total++; if (g1q[0].cyc != rc + 1 || r1q[0].cyc != g1q[0].cyc) $display("FAIL l1_same_cycle got g=%0d r=%0d exp=%0d", g1q[0].cyc, r1q[0].cyc, rc + 1); else passed++;
            total++; if (g1q[1].cyc != g1q[0].cyc + 2 || r1q[1].cyc != g1q[1].cyc) $display("FAIL l1_spacing got g=%0d r=%0d exp=%0d", g1q[1].cyc, r1q[1].cyc, g1q[0].cyc + 2); else passed++;
            for (int k = 0; k < 2; k++) begin
                total++;
                if (r1q[k].v !== exp_q[k].v || r1q[k].d !== exp_q[k].d)
                    $display("FAIL l1_resp%0d got v=%b d=%h exp v=%b d=%h", k, r1q[k].v, r1q[k].d, exp_q[k].v, exp_q[k].d);
                else passed++;
            end
        end
        total++; if (l1_resp_data !== {WW{1'b0}}) $display("FAIL l1_resp_data_idle got=%h exp=0", l1_resp_data); else passed++;
    endtask

    initial begin
        reset = 1'b1;
        req_load = '0; req_write = '0; req_load_addr = '0; req_write_addr = '0; req_write_data = '0;
        l1_req_load = '0; l1_req_write = '0; l1_req_load_addr = '0; l1_req_write_addr = '0; l1_req_write_data = '0;
        test_reset();
        test_write_load();
        test_round_robin(0, 16'h1100);
        test_round_robin(2, 16'h2200);
        test_wrap();
        test_conflict();
        test_reset_mid();
        test_latency1();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/main_memory_responder.md
Name: main_memory_responder

Overview:
- Responder side of the processing-block main-memory interface. Processing blocks issue load and write requests; this block serves them.
- Arbitrates load/write requests from NUM_BLOCKS processing blocks round-robin.
- Owns a single-port main-memory array of CORES*BITS-wide words.
- Commits writes and returns load data after a fixed LATENCY, with a one-hot grant/response handshake per requester.

Parameters:
- NUM_BLOCKS, 4, number of requesting processing blocks.
- CORES, 32, lanes per word.
- BITS, 16, bits per lane; word width WW = CORES*BITS.
- ADDR_BITS, 10, memory depth = 2**ADDR_BITS words.
- LATENCY, 2, cycles from arbitration edge to resp_valid; must be >= 1.

Ports:
- clock  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- req_load  in  NUM_BLOCKS  per-block load request (the block's load_ctrl).
- req_write  in  NUM_BLOCKS  per-block write request (the block's write_ctrl).
- req_load_addr  in  NUM_BLOCKS*16  packed per-block load address; block i at [i*16 +: 16].
- req_write_addr  in  NUM_BLOCKS*16  packed per-block write address.
- req_write_data  in  NUM_BLOCKS*WW  packed per-block write data.
- grant  out  NUM_BLOCKS  one-hot; one-cycle pulse to the arbitration winner.
- resp_valid  out  NUM_BLOCKS  one-hot; one-cycle pulse when load data is valid.
- resp_data  out  WW  shared load-return bus, valid only while resp_valid is nonzero.
- busy  out  1  high whenever state != IDLE.
- err_conflict  out  1  sticky; set when one block asserts load and write in the same arbitrated request.

Behaviour:
- Reset: grant=0, resp_valid=0, resp_data=0, busy=0, err_conflict=0, state=IDLE, rr pointer=0, latency counter=0.
- Reset has priority over all other activity. Reset mid-operation aborts the access: no grant or resp pulse follows it. Memory contents are NOT reset. A write already committed stays committed.
- Requester protocol: hold the request and its addr/data stable until grant is seen high at a posedge, then deassert at that edge.
- Addressing: only addr[ADDR_BITS-1:0] is used; higher bits are ignored, so addresses wrap modulo depth.
- States: IDLE, HOLD, WAIT, RESP.
- IDLE, no request: remain in IDLE.
- IDLE, any req_load|req_write bit set at posedge E0:
  - Winner = first requesting index at or after the rr pointer, searching upward with wrap.
  - rr pointer <= winner+1 (mod NUM_BLOCKS).
  - grant[winner] is high for the cycle following E0.
- Write winner, or winner with both req bits set:
  - mem[waddr] <= wdata at E0.
  - Conflict case only: err_conflict <= 1 and the load is dropped.
  - Next state HOLD (one cycle), then IDLE. No resp_valid is produced.
- Load winner:
  - mem[laddr] is captured into the read register at E0.
  - resp_valid[winner] and resp_data are high/valid for exactly the cycle beginning at edge E0+LATENCY.
  - LATENCY=1: the resp cycle coincides with the grant cycle (state RESP directly).
  - LATENCY>1: WAIT counts LATENCY-1 cycles, then RESP.
  - After RESP, state returns to IDLE.
- No arbitration takes place outside IDLE. Minimum op spacing: write 2 cycles; load LATENCY+1 cycles.
- Read-after-write: a load arbitrated after a write to the same address returns the new data.
- resp_data returns to 0 after the RESP cycle.
- A requester deasserting before grant (protocol violation) is not served. There is no error flag for it.
- Simultaneous requests from all blocks: each is served once, in rotating order, with no starvation.

Decomposition:
- Package mem_resp_pkg holds:
  - the state_t enum (IDLE, HOLD, WAIT, RESP);
  - the function to compute WW from CORES and BITS;
  - the localparam for the latency-counter width, $clog2(LATENCY+1).
- Sub-module rr_arbiter #(N): inputs req[N], ptr; outputs one-hot gnt and winner index. Purely combinational; the pointer register lives in the parent.

Test Plan:
- Single write then load, block 0, addr 5, data all lanes 16'h3F80:
  - grant[0] is seen one cycle after the write request.
  - The load gives resp_valid[0] at E0+2 with resp_data={32{16'h3F80}}.
- All 4 blocks request loads at once from addrs 1..4, each preloaded with a distinct value:
  - grants arrive in order 0,1,2,3, spaced 3 cycles apart;
  - each resp_data matches its address.
  - Repeat with rr pointer at 2: order is 2,3,0,1.
- Address wrap: write addr 16'h0405 then load addr 16'h0005 -> the same word is returned.
- Block 1 asserts load and write together at addr 7, data 16'hAAAA:
  - write committed, err_conflict=1 and sticky;
  - no resp_valid[1] follows.
- Reset asserted during WAIT of a load:
  - next cycle all outputs are 0 and state is IDLE;
  - no resp_valid appears afterwards;
  - earlier written data is still readable.
- LATENCY=1 build: grant[0] and resp_valid[0] are high in the same cycle, and the next load is granted 2 cycles later.
